// File: rtl/hc595_shift_out.sv
// hc595_shift_out: serialises {seg, sel} into two cascaded 74HC595s.
// It then pulses ST_CP so the display pins update atomically.
// Optional build macro: HC595_CHANGE_ONLY_EN. When it is defined, a frame is
// sent only when the input word differs from the last latched word.
module hc595_shift_out #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] sel,
  input  logic [7:0] seg,
  output logic       sh_cp,
  output logic       st_cp,
  output logic       ds,
  output logic       oe_n,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_t;

  // Last count value of a CLK_DIV-long phase.
  localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

  state_t      state_r;
  logic [15:0] shift_r;
  logic [3:0]  bit_r;
  logic [7:0]  phase_r;

  logic [15:0] word_s;
  logic        start_s;
  logic        phase_end_s;
  logic        finish_s;

`ifdef HC595_CHANGE_ONLY_EN
  logic [15:0] last_word_r;
  logic        last_valid_r;
`endif

  assign word_s      = {seg, sel};
  assign phase_end_s = (phase_r == PHASE_LAST);

  // Decide whether IDLE may launch a new frame this cycle.
  always_comb begin
    start_s = 1'b0;
`ifdef HC595_CHANGE_ONLY_EN
    if (en && ((word_s != last_word_r) || !last_valid_r)) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
`else
    if (en) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
`endif
  end

  // The last cycle of the ST_CP high phase ends the frame.
  always_comb begin
    finish_s = 1'b0;
    if ((state_r == LATCH) && phase_end_s && st_cp) begin
      finish_s = 1'b1;
    end else begin
      finish_s = 1'b0;
    end
  end

  // Frame sequencer: LOAD capture, 16 SH_CP bit slots, ST_CP latch pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shift_r    <= 16'h0000;
      bit_r      <= 4'd0;
      phase_r    <= 8'd0;
      sh_cp      <= 1'b0;
      st_cp      <= 1'b0;
      ds         <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_r)
        IDLE: begin
          sh_cp   <= 1'b0;
          st_cp   <= 1'b0;
          phase_r <= 8'd0;
          bit_r   <= 4'd0;
          if (start_s) begin
            // The word is frozen here; later input changes wait for the next frame.
            state_r <= LOAD;
            shift_r <= word_s;
            ds      <= word_s[15];
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end

        LOAD: begin
          // First bit is already on DS; its low phase starts next cycle.
          state_r <= SHIFT;
          phase_r <= 8'd0;
          bit_r   <= 4'd0;
        end

        SHIFT: begin
          if (phase_end_s) begin
            phase_r <= 8'd0;
            if (!sh_cp) begin
              sh_cp <= 1'b1;
            end else if (bit_r == 4'd15) begin
              // The last falling edge of SH_CP opens the latch phase.
              sh_cp   <= 1'b0;
              state_r <= LATCH;
            end else begin
              // DS changes only together with the SH_CP falling edge.
              sh_cp   <= 1'b0;
              bit_r   <= bit_r + 4'd1;
              shift_r <= {shift_r[14:0], 1'b0};
              ds      <= shift_r[14];
            end
          end else begin
            phase_r <= phase_r + 8'd1;
          end
        end

        LATCH: begin
          sh_cp <= 1'b0;
          if (phase_end_s) begin
            phase_r <= 8'd0;
            if (!st_cp) begin
              st_cp <= 1'b1;
            end else begin
              st_cp      <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state_r    <= IDLE;
            end
          end else begin
            phase_r <= phase_r + 8'd1;
          end
        end

        default: begin
          state_r <= IDLE;
          sh_cp   <= 1'b0;
          st_cp   <= 1'b0;
          busy    <= 1'b0;
          phase_r <= 8'd0;
          bit_r   <= 4'd0;
        end
      endcase
    end
  end

  // Blank the display when refresh stops; unblank only once a full frame is latched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oe_n <= 1'b1;
    end else if (!en) begin
      oe_n <= 1'b1;
    end else if (finish_s) begin
      oe_n <= 1'b0;
    end else begin
      oe_n <= oe_n;
    end
  end

`ifdef HC595_CHANGE_ONLY_EN
  // Remember the word at capture; it is marked valid once its frame is latched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_word_r  <= 16'h0000;
      last_valid_r <= 1'b0;
    end else begin
      if ((state_r == IDLE) && start_s) begin
        last_word_r <= word_s;
      end else begin
        last_word_r <= last_word_r;
      end
      if (finish_s) begin
        last_valid_r <= 1'b1;
      end else begin
        last_valid_r <= last_valid_r;
      end
    end
  end
`endif

endmodule
